prbs_test_sequencer: RTL and testbench
======================================

Name: prbs_test_sequencer

Overview:
- Run controller for the PRBS generator / pattern detector datapath.
- Per run it:
  - latches a test pattern and repeat count from the requester;
  - holds the datapath in reset for a fixed number of cycles;
  - releases it and times how long the detector takes to raise its found flag;
  - reports pass/fail plus the measured latency with a one-cycle done pulse.
- Sits between the test requester (CPU/bench) and the PRBS+detector pair, driving their shared reset, pattern and count inputs.

Parameters:
- RST_CYCLES, 2, number of cycles dp_rst is held high in LOAD (must be >= 1).
- MAX_WAIT, 64, RUN cycles allowed before declaring timeout (1..255).

Ports:
- CLK  input  1  system clock, all state on rising edge.
- RST  input  1  asynchronous, active-high reset.
- start  input  1  request a run; sampled only in IDLE.
- cfg_pattern  input  8  pattern to generate/detect; captured on accepted start.
- cfg_count  input  8  pattern repeat count; captured on accepted start.
- dp_found  input  1  found flag from pattern detector.
- dp_rst  output  1  reset to PRBS and detector.
- dp_pattern  output  8  pattern to PRBS.
- dp_n_pattern  output  8  repeat count to PRBS and detector.
- busy  output  1  high from accepted start until the DONE cycle inclusive.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  run result; valid with done, held until next accepted start.
- found_cycles  output  8  measured RUN cycles; valid with done, held until next accepted start.

Behaviour:
- Reset values (async, immediate):
  - state=IDLE, dp_rst=1, dp_pattern=0, dp_n_pattern=0;
  - busy=0, done=0, pass=0, found_cycles=0.
- dp_rst is high in every state except RUN, so the datapath idles in reset.
- Outputs are registered, not decoded combinationally from dp_found.
- IDLE, start=1 with cfg_count!=0:
  - capture cfg_pattern/cfg_count into dp_pattern/dp_n_pattern;
  - clear pass and found_cycles;
  - busy=1; go to LOAD.
- IDLE, start=1 with cfg_count==0 (illegal count):
  - capture pattern/count as above;
  - go directly to DONE with pass=0, found_cycles=0;
  - datapath is never released.
- LOAD:
  - dp_rst=1; internal counter runs RST_CYCLES cycles, then go to RUN;
  - dp_found is ignored here.
- RUN:
  - dp_rst=0; wait counter starts at 1 in the first RUN cycle;
  - dp_found=1 in RUN cycle k: found_cycles=k, pass=1, go to DONE;
  - no found by end of RUN cycle MAX_WAIT: found_cycles=MAX_WAIT, pass=0, go to DONE (timeout);
  - dp_found in the same cycle as the timeout counts as found (pass=1).
- DONE:
  - done=1 and busy=1 for exactly one cycle, dp_rst=1, then return to IDLE;
  - a start asserted during DONE is ignored.
- start while busy is ignored; no queuing.
- dp_pattern/dp_n_pattern stay stable from capture through the end of the run and remain held in IDLE.
- Cycle timeline, start accepted at edge t:
  - LOAD occupies cycles t+1..t+RST_CYCLES;
  - first RUN cycle is t+RST_CYCLES+1;
  - done asserts the cycle after found or timeout.
- Reset asserted mid-run: immediate return to reset values, including dp_rst=1; no done pulse.
- The wait counter is 8 bits and cannot wrap because MAX_WAIT <= 255.

Decomposition:
- Shared package prbs_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DONE);
  - PATTERN_W = 8;
  - default RST_CYCLES and MAX_WAIT constants, also used by the top-level integration.
- Sub-module: none. The FSM and its two counters fit in one module.
- The integration top instantiates prbs_test_sequencer alongside the PRBS and detector blocks, with dp_* wired to their RST/IN/n_pattern/Pattern_Found.

Test Plan:
- Reset then idle: release RST, hold start=0 for 10 cycles -> dp_rst=1, busy=0, done=0, found_cycles=0 throughout.
- Nominal pass: start with cfg_pattern=0xA5, cfg_count=3, default parameters; bench drives dp_found=1 in 4th RUN cycle -> dp_rst low for 4 cycles, dp_pattern=0xA5, dp_n_pattern=3; done 1 cycle later with pass=1, found_cycles=4; busy drops the cycle after done.
- Timeout: cfg_pattern=0x3C, cfg_count=2, dp_found held 0 -> exactly 64 RUN cycles, then done with pass=0, found_cycles=64; dp_rst returns high.
- Zero count: start with cfg_count=0 -> no LOAD/RUN, dp_rst never low; done in the cycle after start with pass=0, found_cycles=0.
- Ignored start / boundaries:
  - start pulsed during LOAD, RUN and DONE -> no effect on dp_pattern or the run;
  - dp_found during LOAD -> ignored;
  - dp_found coinciding with RUN cycle 64 -> pass=1, found_cycles=64.
- Async reset mid-RUN: assert RST between clock edges at RUN cycle 10 -> outputs return to reset values immediately; no done pulse; a new start after release runs normally.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS test sequencer and its integration top.
// The default run parameters live here so the sequencer and the top level
// that wires it to the PRBS generator and detector agree on them.
package prbs_pkg;

    localparam int PATTERN_W      = 8;
    localparam int CNT_W          = 8;
    localparam int DEF_RST_CYCLES = 2;
    localparam int DEF_MAX_WAIT   = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seqState_e;

endpackage

// File: rtl/prbs_test_sequencer.sv
// Run controller for the PRBS generator / pattern detector pair.
// A run latches the requested pattern and repeat count, holds the datapath
// in reset for RST_CYCLES cycles, releases it, and counts RUN cycles until
// the detector raises its found flag or MAX_WAIT cycles have elapsed. The
// result is reported with a one-cycle done pulse; pass and found_cycles are
// held until the next run is accepted. All outputs come straight from flops.
// RST_CYCLES must be 1..255 and MAX_WAIT 1..255, so the 8-bit counter never wraps.
module prbs_test_sequencer
    import prbs_pkg::*;
#(
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int MAX_WAIT   = DEF_MAX_WAIT
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [PATTERN_W-1:0] cfg_pattern,
    input  logic [PATTERN_W-1:0] cfg_count,
    input  logic                 dp_found,
    output logic                 dp_rst,
    output logic [PATTERN_W-1:0] dp_pattern,
    output logic [PATTERN_W-1:0] dp_n_pattern,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     found_cycles
);

    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(MAX_WAIT);

    seqState_e            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic                 dpRst_q;
    logic [PATTERN_W-1:0] dpPattern_q;
    logic [PATTERN_W-1:0] dpCount_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
    logic [CNT_W-1:0]     foundCycles_q;

    // Incremented count, shared by the LOAD hold timer and the RUN wait timer.
    assign cnt_d = cnt_q + CNT_W'(1);

    // Run FSM: one counter times the reset hold in LOAD, then measures latency in RUN.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            dpRst_q       <= 1'b1;
            dpPattern_q   <= '0;
            dpCount_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            foundCycles_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q  <= 1'b0;
                    dpRst_q <= 1'b1;
                    if (start) begin
                        dpPattern_q   <= cfg_pattern;
                        dpCount_q     <= cfg_count;
                        pass_q        <= 1'b0;
                        foundCycles_q <= '0;
                        busy_q        <= 1'b1;
                        cnt_q         <= CNT_W'(1);
                        if (cfg_count == '0) begin
                            // A zero repeat count can never be detected, so
                            // report a failed run without touching the datapath.
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end

                ST_LOAD: begin
                    dpRst_q <= 1'b1;
                    if (cnt_q == LOAD_LAST) begin
                        state_q <= ST_RUN;
                        dpRst_q <= 1'b0;
                        cnt_q   <= CNT_W'(1);
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                ST_RUN: begin
                    // A found flag on the final allowed cycle still counts as a pass.
                    if (dp_found) begin
                        state_q       <= ST_DONE;
                        dpRst_q       <= 1'b1;
                        done_q        <= 1'b1;
                        pass_q        <= 1'b1;
                        foundCycles_q <= cnt_q;
                    end else if (cnt_q == RUN_LAST) begin
                        state_q       <= ST_DONE;
                        dpRst_q       <= 1'b1;
                        done_q        <= 1'b1;
                        pass_q        <= 1'b0;
                        foundCycles_q <= RUN_LAST;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                    dpRst_q <= 1'b1;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    dpRst_q <= 1'b1;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dp_rst       = dpRst_q;
    assign dp_pattern   = dpPattern_q;
    assign dp_n_pattern = dpCount_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign found_cycles = foundCycles_q;

endmodule

// File: tb/tb_prbs_test_sequencer.sv
// Bench for the PRBS run sequencer. Each run pushes its expected result
// (pass, found_cycles, number of cycles the datapath was out of reset) into
// a queue; a monitor pops and compares it whenever done pulses. Directed
// stimulus also checks per-cycle control outputs at chosen points.
module tb_prbs_test_sequencer;

    logic       CLK;
    logic       RST;
    logic       start;
    logic [7:0] cfg_pattern;
    logic [7:0] cfg_count;
    logic       dp_found;
    logic       dp_rst;
    logic [7:0] dp_pattern;
    logic [7:0] dp_n_pattern;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] found_cycles;

    typedef struct {
        logic       expPass;
        logic [7:0] expFound;
        int         expLow;
    } runExp_t;

    runExp_t expQ[$];
    int      checks    = 0;
    int      failures  = 0;
    int      lowCount  = 0;
    int      doneCount = 0;

    prbs_test_sequencer #(.RST_CYCLES(2), .MAX_WAIT(64)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .start        (start),
        .cfg_pattern  (cfg_pattern),
        .cfg_count    (cfg_count),
        .dp_found     (dp_found),
        .dp_rst       (dp_rst),
        .dp_pattern   (dp_pattern),
        .dp_n_pattern (dp_n_pattern),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .found_cycles (found_cycles)
    );

    // Free-running 10 ns clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [7:0] pat, input logic [7:0] cnt, input logic f);
        start       = s;
        cfg_pattern = pat;
        cfg_count   = cnt;
        dp_found    = f;
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic pushExp(input logic p, input logic [7:0] fc, input int low);
        runExp_t e;
        e.expPass  = p;
        e.expFound = fc;
        e.expLow   = low;
        expQ.push_back(e);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_dp_rst"}, 32'(dp_rst), 32'd1);
        checkOutput({tag, "_dp_pattern"}, 32'(dp_pattern), 32'd0);
        checkOutput({tag, "_dp_n_pattern"}, 32'(dp_n_pattern), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_pass"}, 32'(pass), 32'd0);
        checkOutput({tag, "_found_cycles"}, 32'(found_cycles), 32'd0);
    endtask

    // Monitor: counts released-datapath cycles and scores every done pulse.
    initial begin
        forever begin
            @(negedge CLK);
            if (RST) begin
                lowCount = 0;
            end else begin
                if (dp_rst == 1'b0) lowCount++;
                if (done) begin
                    doneCount++;
                    if (expQ.size() == 0) begin
                        checkOutput("done_without_expect", 32'(expQ.size()), 32'd1);
                    end else begin
                        runExp_t e;
                        e = expQ.pop_front();
                        checkOutput("sb_pass", 32'(pass), 32'(e.expPass));
                        checkOutput("sb_found_cycles", 32'(found_cycles), 32'(e.expFound));
                        checkOutput("sb_released_cycles", 32'(lowCount), 32'(e.expLow));
                        checkOutput("sb_busy_with_done", 32'(busy), 32'd1);
                    end
                    lowCount = 0;
                end
            end
        end
    end

    // Directed run sequence.
    initial begin
        RST = 1'b1;
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        #12;
        checkResetValues("reset");
        RST = 1'b0;

        for (int i = 0; i < 10; i++) begin
            nextCycle();
            checkOutput("idle_dp_rst", 32'(dp_rst), 32'd1);
            checkOutput("idle_busy", 32'(busy), 32'd0);
            checkOutput("idle_done", 32'(done), 32'd0);
            checkOutput("idle_found_cycles", 32'(found_cycles), 32'd0);
        end

        // Nominal pass, found in RUN cycle 4, with ignored starts and an early found.
        applyStimulus(1'b1, 8'hA5, 8'd3, 1'b0);
        pushExp(1'b1, 8'd4, 4);
        nextCycle();
        checkOutput("nom_load_busy", 32'(busy), 32'd1);
        checkOutput("nom_load_dp_rst", 32'(dp_rst), 32'd1);
        checkOutput("nom_dp_pattern", 32'(dp_pattern), 32'hA5);
        checkOutput("nom_dp_n_pattern", 32'(dp_n_pattern), 32'd3);
        applyStimulus(1'b1, 8'hFF, 8'd9, 1'b1);
        nextCycle();
        checkOutput("nom_load2_dp_rst", 32'(dp_rst), 32'd1);
        checkOutput("nom_load2_pattern", 32'(dp_pattern), 32'hA5);
        applyStimulus(1'b0, 8'hFF, 8'd9, 1'b0);
        nextCycle();
        checkOutput("nom_run1_dp_rst", 32'(dp_rst), 32'd0);
        applyStimulus(1'b1, 8'h12, 8'd7, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 8'h12, 8'd7, 1'b0);
        checkOutput("nom_run2_pattern", 32'(dp_pattern), 32'hA5);
        nextCycle();
        nextCycle();
        checkOutput("nom_run4_done", 32'(done), 32'd0);
        checkOutput("nom_run4_dp_rst", 32'(dp_rst), 32'd0);
        dp_found = 1'b1;
        nextCycle();
        dp_found = 1'b0;
        checkOutput("nom_done_pulse", 32'(done), 32'd1);
        checkOutput("nom_done_dp_rst", 32'(dp_rst), 32'd1);
        applyStimulus(1'b1, 8'h66, 8'd5, 1'b0);
        nextCycle();
        start = 1'b0;
        checkOutput("nom_after_busy", 32'(busy), 32'd0);
        checkOutput("nom_after_done", 32'(done), 32'd0);
        checkOutput("nom_held_pattern", 32'(dp_pattern), 32'hA5);
        checkOutput("nom_held_count", 32'(dp_n_pattern), 32'd3);
        checkOutput("nom_held_pass", 32'(pass), 32'd1);
        checkOutput("nom_held_found", 32'(found_cycles), 32'd4);
        nextCycle();
        checkOutput("nom_start_in_done_ignored", 32'(busy), 32'd0);

        // Timeout: no found for 64 RUN cycles.
        applyStimulus(1'b1, 8'h3C, 8'd2, 1'b0);
        pushExp(1'b0, 8'd64, 64);
        nextCycle();
        start = 1'b0;
        checkOutput("to_cleared_pass", 32'(pass), 32'd0);
        checkOutput("to_cleared_found", 32'(found_cycles), 32'd0);
        checkOutput("to_dp_n_pattern", 32'(dp_n_pattern), 32'd2);
        nextCycle();
        nextCycle();
        repeat (63) nextCycle();
        checkOutput("to_run64_dp_rst", 32'(dp_rst), 32'd0);
        checkOutput("to_run64_done", 32'(done), 32'd0);
        nextCycle();
        checkOutput("to_done_pulse", 32'(done), 32'd1);
        nextCycle();
        checkOutput("to_after_dp_rst", 32'(dp_rst), 32'd1);
        checkOutput("to_after_busy", 32'(busy), 32'd0);
        checkOutput("to_held_found", 32'(found_cycles), 32'd64);

        // Found coinciding with the last allowed RUN cycle.
        applyStimulus(1'b1, 8'hC3, 8'd2, 1'b0);
        pushExp(1'b1, 8'd64, 64);
        nextCycle();
        start = 1'b0;
        nextCycle();
        nextCycle();
        repeat (63) nextCycle();
        dp_found = 1'b1;
        nextCycle();
        dp_found = 1'b0;
        checkOutput("edge_done_pulse", 32'(done), 32'd1);
        nextCycle();
        checkOutput("edge_held_pass", 32'(pass), 32'd1);
        checkOutput("edge_held_found", 32'(found_cycles), 32'd64);

        // Zero count: straight to DONE, datapath never released.
        applyStimulus(1'b1, 8'h11, 8'd0, 1'b0);
        pushExp(1'b0, 8'd0, 0);
        nextCycle();
        start = 1'b0;
        checkOutput("zero_done_pulse", 32'(done), 32'd1);
        checkOutput("zero_busy", 32'(busy), 32'd1);
        checkOutput("zero_dp_rst", 32'(dp_rst), 32'd1);
        checkOutput("zero_dp_pattern", 32'(dp_pattern), 32'h11);
        checkOutput("zero_dp_n_pattern", 32'(dp_n_pattern), 32'd0);
        nextCycle();
        checkOutput("zero_after_busy", 32'(busy), 32'd0);
        checkOutput("zero_after_dp_rst", 32'(dp_rst), 32'd1);

        // Asynchronous reset in RUN cycle 10, then a fresh run.
        applyStimulus(1'b1, 8'h5A, 8'd5, 1'b0);
        nextCycle();
        start = 1'b0;
        nextCycle();
        nextCycle();
        repeat (9) nextCycle();
        checkOutput("ar_run10_dp_rst", 32'(dp_rst), 32'd0);
        #2;
        RST = 1'b1;
        #1;
        checkResetValues("async_reset");
        nextCycle();
        RST = 1'b0;
        nextCycle();
        checkOutput("ar_idle_busy", 32'(busy), 32'd0);
        checkOutput("ar_idle_dp_rst", 32'(dp_rst), 32'd1);
        applyStimulus(1'b1, 8'h77, 8'd1, 1'b0);
        pushExp(1'b1, 8'd1, 1);
        nextCycle();
        start = 1'b0;
        checkOutput("ar_new_pattern", 32'(dp_pattern), 32'h77);
        nextCycle();
        nextCycle();
        dp_found = 1'b1;
        nextCycle();
        dp_found = 1'b0;
        checkOutput("ar_new_done", 32'(done), 32'd1);
        nextCycle();
        checkOutput("ar_new_pass", 32'(pass), 32'd1);

        repeat (3) nextCycle();
        checkOutput("sb_drained", 32'(expQ.size()), 32'd0);
        checkOutput("done_pulse_total", 32'(doneCount), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
